// File: rtl/csa_accumulator_pkg.sv
// Shared types and default sizing for the carry-save frame accumulator.
package csa_acc_pkg;

  localparam int CSA_DEF_WIDTH = 8;
  localparam int CSA_DEF_ACC_W = 16;

  typedef enum logic [1:0] {
    CSA_IDLE    = 2'd0,
    CSA_ACCUM   = 2'd1,
    CSA_RESOLVE = 2'd2,
    CSA_OUTPUT  = 2'd3
  } csa_state_e;

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand-in / result-out handshake bundle for csa_accumulator.
// out_ovf exists only when CSA_ACC_OVF_EN is defined.
interface csa_acc_if
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = CSA_DEF_WIDTH,
  parameter int ACC_W = CSA_DEF_ACC_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;
`ifdef CSA_ACC_OVF_EN
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/csa_accumulator_csa42_row.sv
// Row of N 4:2 compressor cells; each cell is two chained full adders and
// passes its first-stage carry sideways to the next cell (no ripple path).
module csa42_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] s_i,
  input  logic [N-1:0] c_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o,
  output logic         cout_o
);

  logic [N:0]   chain;
  logic [N-1:0] mid;

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    full_adder u_fa_lo (
      .a  (s_i[i]),
      .b  (c_i[i]),
      .ci (a_i[i]),
      .s  (mid[i]),
      .co (chain[i+1])
    );

    full_adder u_fa_hi (
      .a  (mid[i]),
      .b  (b_i[i]),
      .ci (chain[i]),
      .s  (sum_o[i]),
      .co (carry_o[i])
    );
  end

  assign cout_o = chain[N];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the leaf cell of the 4:2 compressor row.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// Frame accumulator: beats are summed in carry-save form, then resolved to
// a binary result in one cycle. Optional overflow flag: CSA_ACC_OVF_EN.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = CSA_DEF_WIDTH,
  parameter int ACC_W = CSA_DEF_ACC_W
) (
  input logic      clk,
  input logic      rst,
  csa_acc_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = CSA_IDLE;
  localparam logic [1:0] ST_ACCUM   = CSA_ACCUM;
  localparam logic [1:0] ST_RESOLVE = CSA_RESOLVE;
  localparam logic [1:0] ST_OUTPUT  = CSA_OUTPUT;

  if (ACC_W < WIDTH + 1) begin : g_bad_width
    $error("csa_accumulator: ACC_W must be at least WIDTH+1");
  end

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             out_fire;
  logic [ACC_W-1:0] row_s_in, row_c_in;
  logic [ACC_W-1:0] op_a, op_b;
  logic [ACC_W-1:0] row_sum, row_carry, row_c_next;
  logic             row_cout;

  assign accept   = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  assign op_a = {{(ACC_W-WIDTH){1'b0}}, bus.in_a};
  assign op_b = {{(ACC_W-WIDTH){1'b0}}, bus.in_b};

  // A frame starting in IDLE sees a zero accumulator regardless of S/C contents.
  assign row_s_in = (state_q == ST_IDLE) ? {ACC_W{1'b0}} : s_q;
  assign row_c_in = (state_q == ST_IDLE) ? {ACC_W{1'b0}} : c_q;

  csa42_row #(.N(ACC_W)) u_row (
    .s_i     (row_s_in),
    .c_i     (row_c_in),
    .a_i     (op_a),
    .b_i     (op_b),
    .sum_o   (row_sum),
    .carry_o (row_carry),
    .cout_o  (row_cout)
  );

  assign row_c_next = {row_carry[ACC_W-2:0], 1'b0};

`ifdef CSA_ACC_OVF_EN
  logic [ACC_W:0] resolve_full;
  logic [ACC_W-1:0] resolve_sum;
  logic           ovf_q, ovf_d;
  logic           row_ovf;

  assign resolve_full = {1'b0, s_q} + {1'b0, c_q};
  assign resolve_sum  = resolve_full[ACC_W-1:0];
  assign row_ovf      = row_carry[ACC_W-1] | row_cout;

  // Sticky overflow: restarts with each frame, collects dropped carries.
  always_comb begin
    ovf_d = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ovf_d = row_ovf;
        end else begin
          ovf_d = ovf_q;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          ovf_d = ovf_q | row_ovf;
        end else begin
          ovf_d = ovf_q;
        end
      end
      ST_RESOLVE: ovf_d = ovf_q | resolve_full[ACC_W];
      ST_OUTPUT:  ovf_d = ovf_q;
      default:    ovf_d = 1'b0;
    endcase
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_ovf = ovf_q;
`else
  logic [ACC_W-1:0] resolve_sum;
  logic             unused_msb_carries;

  assign resolve_sum        = s_q + c_q;
  assign unused_msb_carries = row_carry[ACC_W-1] | row_cout;
`endif

  // Frame FSM and carry-save datapath next-state.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          s_d     = row_sum;
          c_d     = row_c_next;
          state_d = bus.in_last ? ST_RESOLVE : ST_ACCUM;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESOLVE: begin
        result_d = resolve_sum;
        state_d  = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_fire) begin
          state_d = ST_IDLE;
          s_d     = {ACC_W{1'b0}};
          c_d     = {ACC_W{1'b0}};
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = {ACC_W{1'b0}};
        c_d     = {ACC_W{1'b0}};
      end
    endcase
    out_valid_d = (state_d == ST_OUTPUT);
    in_ready_d  = (state_d == ST_IDLE) | (state_d == ST_ACCUM);
  end

  // State, accumulator and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_q         <= {ACC_W{1'b0}};
      c_q         <= {ACC_W{1'b0}};
      result_q    <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator (WIDTH=8, ACC_W=16).
module tb_csa_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  csa_acc_if #(.WIDTH(8), .ACC_W(16)) bus ();

  csa_accumulator #(.WIDTH(8), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; holds the beat across one posedge, returns at next negedge.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_inputs();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h00;
    bus.in_b     = 8'h00;
    bus.in_last  = 1'b0;
  endtask

  // Returns number of extra negedges until out_valid, or -1 if bound expires.
  task automatic wait_valid(input int max, output int cycles);
    cycles = -1;
    for (int i = 0; i < max; i++) begin
      if (bus.out_valid === 1'b1) begin
        cycles = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    release_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_result !== 16'h0000) begin bad++; $display("FAIL reset_out_result got=%h want=0000", bus.out_result); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
`ifdef CSA_ACC_OVF_EN
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf); end
`endif
  endtask

  task automatic test_single_beat();
    int cyc;
    drive_beat(8'hFF, 8'h01, 1'b1);
    release_inputs();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL single_resolve_in_ready got=%b want=0", bus.in_ready); end
    wait_valid(20, cyc);
    total++; if (cyc + 1 !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", cyc + 1); end
    total++; if (bus.out_result !== 16'h0100) begin bad++; $display("FAIL single_result got=%h want=0100", bus.out_result); end
`ifdef CSA_ACC_OVF_EN
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b want=0", bus.out_ovf); end
`endif
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_multi_beat();
    int cyc;
    drive_beat(8'd10, 8'd20, 1'b0);
    drive_beat(8'd30, 8'd40, 1'b0);
    drive_beat(8'd50, 8'd60, 1'b1);
    release_inputs();
    wait_valid(20, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL multi_latency got=%0d want=1", cyc); end
    total++; if (bus.out_result !== 16'h00D2) begin bad++; $display("FAIL multi_result got=%h want=00d2", bus.out_result); end
`ifdef CSA_ACC_OVF_EN
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL multi_ovf got=%b want=0", bus.out_ovf); end
`endif
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    drive_beat(8'd7, 8'd9, 1'b1);
    release_inputs();
    wait_valid(20, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL bp_latency got=%0d want=1", cyc); end
    // Junk beats offered while in_ready=0 must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hAA;
    bus.in_b     = 8'h55;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, bus.out_valid); end
      total++; if (bus.out_result !== 16'h0010) begin bad++; $display("FAIL bp_result[%0d] got=%h want=0010", i, bus.out_result); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, bus.in_ready); end
    end
    release_inputs();
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b want=0", bus.out_valid); end
    drive_beat(8'd3, 8'd4, 1'b1);
    release_inputs();
    wait_valid(20, cyc);
    total++; if (bus.out_result !== 16'h0007) begin bad++; $display("FAIL bp_next_result got=%h want=0007", bus.out_result); end
    @(negedge clk);
  endtask

  task automatic test_long_frame();
    int cyc;
    for (int i = 0; i < 258; i++) begin
      drive_beat(8'hFF, 8'hFF, (i == 257));
    end
    release_inputs();
    wait_valid(20, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL long_latency got=%0d want=1", cyc); end
    total++; if (bus.out_result !== 16'h01FC) begin bad++; $display("FAIL long_result got=%h want=01fc", bus.out_result); end
`ifdef CSA_ACC_OVF_EN
    total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL long_ovf got=%b want=1", bus.out_ovf); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int cyc;
    int n_valid;
    logic [15:0] seen;
    drive_beat(8'd5, 8'd6, 1'b0);
    drive_beat(8'd7, 8'd8, 1'b0);
    release_inputs();
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    // Reset while a result is being held.
    bus.out_ready = 1'b0;
    drive_beat(8'd9, 8'd9, 1'b1);
    release_inputs();
    wait_valid(20, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL rstout_latency got=%0d want=1", cyc); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstout_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_result !== 16'h0000) begin bad++; $display("FAIL rstout_result got=%h want=0000", bus.out_result); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive_beat(8'd1, 8'd2, 1'b1);
    release_inputs();
    n_valid = 0;
    seen = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid === 1'b1) begin
        n_valid++;
        seen = bus.out_result;
      end
      @(negedge clk);
    end
    total++; if (n_valid !== 1) begin bad++; $display("FAIL rstmid_result_count got=%0d want=1", n_valid); end
    total++; if (seen !== 16'h0003) begin bad++; $display("FAIL rstmid_result got=%h want=0003", seen); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_backpressure();
    test_long_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: operand width of in_a and in_b.
REQ-002 Parameter ACC_W, default 16: accumulator and result width; ACC_W SHALL be at least WIDTH+1 (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat; transfer when in_valid && in_ready at a clk edge.
REQ-007 in_a  input  WIDTH  unsigned operand, zero-extended to ACC_W.
REQ-008 in_b  input  WIDTH  unsigned operand, zero-extended to ACC_W.
REQ-009 in_last  input  1  marks final beat of a frame.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result; transfer when out_valid && out_ready.
REQ-012 out_result  output  ACC_W  frame sum modulo 2^ACC_W.
REQ-013 out_ovf  output  1  sticky frame overflow flag; present only with CSA_ACC_OVF_EN.

Function
REQ-014 State machine SHALL have states IDLE, ACCUM, RESOLVE, OUTPUT.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, 0 in RESOLVE and OUTPUT.
REQ-016 Carry-save registers S, C (ACC_W each) SHALL hold the running frame sum.
REQ-017 Per accepted beat: one 4:2 compressor row reduces {S, C, a, b} to next {S, C}; a beat accepted in IDLE uses S=C=0.
REQ-018 Row: cell i inputs S[i], C[i], a[i], b[i], cin=cout of cell i-1 (cell 0 cin=0); S_next[i]=sum[i]; C_next[i+1]=carry[i]; C_next[0]=0; cout and carry of cell ACC_W-1 dropped.
REQ-019 Transitions: IDLE to ACCUM on non-last beat; IDLE or ACCUM to RESOLVE on beat with in_last=1; ACCUM holds otherwise.
REQ-020 RESOLVE SHALL last exactly one cycle: out_result register loaded with (S+C) mod 2^ACC_W; then OUTPUT.
REQ-021 out_valid SHALL be 1 exactly in OUTPUT; out_result stable while out_valid=1 and out_ready=0.
REQ-022 Latency: out_valid rises 2 cycles after the edge accepting the last beat.
REQ-023 OUTPUT to IDLE on out handshake; in_ready=1 on the following cycle; S, C cleared.
REQ-024 in_valid while in_ready=0 SHALL be ignored (no beat consumed).
REQ-025 Single-beat frame (in_last on first beat) SHALL yield a+b.

Reset
REQ-026 rst SHALL force IDLE, S=C=0, out_result=0, out_valid=0, out_ovf=0 immediately, independent of clk.
REQ-027 Reset mid-frame or during OUTPUT SHALL discard the frame with no result emitted.

Configuration
REQ-028 Macro CSA_ACC_OVF_EN defined: out_ovf port exists; set when any dropped MSB cout/carry in REQ-018 is 1 or the RESOLVE adder carry-out is 1; cleared on frame start in IDLE; valid with out_valid.
REQ-029 Macro undefined: no out_ovf port, no overflow logic; all other behaviour identical.

Structure
REQ-030 Package csa_acc_pkg SHALL hold the state enum typedef and default WIDTH/ACC_W constants.
REQ-031 One sub-module csa42_row (parameter N): row of N 4:2 cells with cout chain, each cell built from two existing full_adder instances.

Verification (WIDTH=8, ACC_W=16)
REQ-032 Reset asserted/released -> out_valid=0, out_result=16'h0000, in_ready=1, out_ovf=0.
REQ-033 Single beat a=8'hFF, b=8'h01, last=1 -> out_valid 2 cycles later, out_result=16'h0100.
REQ-034 Beats (10,20),(30,40),(50,60 last) -> out_result=16'h00D2, out_ovf=0.
REQ-035 Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; after handshake in_ready=1 next cycle.
REQ-036 258 beats of (8'hFF, 8'hFF) -> out_result=16'h01FC; out_ovf=1 with CSA_ACC_OVF_EN.
REQ-037 Two beats, then rst pulse, then single beat (1,2 last) -> only result 16'h0003 emitted.
